// File: rtl/apb_regfile_ws.sv
// apb_regfile_ws
// APB3 slave register file with these features:
//   - configurable register count and data width
//   - reset value per register
//   - read-only mask
//   - programmable PREADY wait states
//   - PSLVERR on illegal accesses
// Optional feature macro: APB_REGFILE_PSTRB_EN (adds PSTRB byte strobes).
// When the macro is undefined, every write updates the full word.
module apb_regfile_ws #(
    parameter int                             NUM_REGS    = 8,
    parameter int                             DATA_WIDTH  = 32,
    parameter int                             ADDR_WIDTH  = 8,
    parameter int                             WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0]            RO_MASK     = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS  = {(NUM_REGS*DATA_WIDTH){1'b0}}
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int NBYTES = DATA_WIDTH / 8;
    // Counter value at which PREADY is registered high.
    // WAIT_STATES=0 never consults this value.
    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,   // first access-phase cycle, request already latched
        ST_ACCESS = 2'd2
    } state_e;

    // Decide whether an access is illegal.
    // An index outside the bank is always an error.
    // A write to a read-only register is also an error.
    function automatic logic access_err(input logic [IDX_W-1:0] idx, input logic wr);
        logic err;
        err = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            err = (idx == IDX_W'(i)) ? (wr & RO_MASK[i]) : err;
        end
        return err;
    endfunction

    // Expand the byte strobes into a bit mask.
    function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [NBYTES-1:0] strb);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < NBYTES; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    state_e                  state_r, state_s;
    logic [3:0]              cnt_r, cnt_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic                    wr_r, wr_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
    logic [NBYTES-1:0]       strb_r, strb_s;
    logic                    err_r, err_s;
    logic                    pready_r, pready_s;
    logic                    pslverr_r, pslverr_s;
    logic [DATA_WIDTH-1:0]   prdata_r, prdata_s;
    logic                    commit_s;
    logic [NBYTES-1:0]       in_strb_s;
    logic [IDX_W-1:0]        paddr_idx_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic                    setup_err_s;
    logic [DATA_WIDTH-1:0]   wmask_s;
    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
    logic                    addr_lsb_unused_s;

    assign paddr_idx_s       = PADDR[ADDR_WIDTH-1:2];
    assign addr_lsb_unused_s = ^PADDR[1:0];
    assign setup_err_s       = access_err(paddr_idx_s, PWRITE);
    assign wmask_s           = byte_mask(strb_r);

`ifdef APB_REGFILE_PSTRB_EN
    assign in_strb_s = PSTRB;
`else
    assign in_strb_s = {NBYTES{1'b1}};
`endif

    // Read-index mux: the bus address while idle (zero-wait reads), the latched index otherwise.
    always_comb begin
        rd_idx_s = (state_r == ST_IDLE) ? paddr_idx_s : idx_r;
    end

    // Read-data mux over the bank; out-of-range indices return zero.
    always_comb begin
        rd_word_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_word_s = (rd_idx_s == IDX_W'(i)) ? regs_r[i] : rd_word_s;
        end
    end

    // Next-state logic for the transfer FSM.
    // Also computes the next values of the latched request, the wait counter and the bus outputs.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        wr_s      = wr_r;
        wdata_s   = wdata_r;
        strb_s    = strb_r;
        err_s     = err_r;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_s = ST_SETUP;
                    idx_s   = paddr_idx_s;
                    wr_s    = PWRITE;
                    wdata_s = PWDATA;
                    strb_s  = in_strb_s;
                    err_s   = setup_err_s;
                    cnt_s   = 4'd0;
                    if (WAIT_STATES == 0) begin
                        pready_s  = 1'b1;
                        pslverr_s = setup_err_s;
                        prdata_s  = (!PWRITE && !setup_err_s) ? rd_word_s : '0;
                    end else begin
                        pready_s  = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!PSEL) begin
                    // Abort: master walked away, drop the transfer without a write.
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else if (pready_r) begin
                    if (PENABLE) begin
                        commit_s = wr_r & ~err_r;
                        state_s  = ST_IDLE;
                        cnt_s    = 4'd0;
                    end else begin
                        // Master stalled the access phase; keep presenting the response.
                        state_s   = ST_ACCESS;
                        pready_s  = 1'b1;
                        pslverr_s = pslverr_r;
                        prdata_s  = prdata_r;
                    end
                end else begin
                    state_s = ST_ACCESS;
                    cnt_s   = cnt_r + 4'd1;
                    if (cnt_r == WS_LAST) begin
                        pready_s  = 1'b1;
                        pslverr_s = err_r;
                        prdata_s  = (!wr_r && !err_r) ? rd_word_s : '0;
                    end else begin
                        pready_s  = 1'b0;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state, latched request and registered bus outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            idx_r     <= '0;
            wr_r      <= 1'b0;
            wdata_r   <= '0;
            strb_r    <= '0;
            err_r     <= 1'b0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            wr_r      <= wr_s;
            wdata_r   <= wdata_s;
            strb_r    <= strb_s;
            err_r     <= err_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            prdata_r  <= prdata_s;
        end
    end

    // Register bank: reset values on PRESET.
    // Otherwise apply the byte-masked write at the end of a legal completing write.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && (idx_r == IDX_W'(i))) begin
                    regs_r[i] <= (regs_r[i] & ~wmask_s) | (wdata_r & wmask_s);
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    assign PRDATA  = prdata_r;
    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Self-checking bench for apb_regfile_ws.
// Configuration: 8 x 32-bit registers, 1 wait state, register 7 read-only.
// Build with APB_REGFILE_PSTRB_EN defined to also exercise the byte strobes.
module tb_apb_regfile_ws;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int WS = 1;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
`ifdef APB_REGFILE_PSTRB_EN
    logic [3:0]    PSTRB;
`endif
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t       vecs [20];
    exp_t       sb_q [$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_strb = 4'hF;

    always #5 PCLK = ~PCLK;

    apb_regfile_ws #(
        .NUM_REGS    (NR),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (WS),
        .RO_MASK     (8'h80),
        .RESET_VALS  ({32'h1234_9876, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0000, 32'h0})
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
`ifdef APB_REGFILE_PSTRB_EN
        .PSTRB   (PSTRB),
`endif
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (strb %h)", name, act, exp, last_strb);
        end
    endtask

    task automatic idle();
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    // One APB transfer.
    // The expected result is queued when the setup phase is driven.
    // It is popped and compared when PREADY completes the transfer.
    task automatic xfer(input string name, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        exp_t e;
        @(negedge PCLK);
        chk({name, "_idle_ready"}, {31'b0, PREADY}, 32'd0);
        PSEL      = 1'b1;
        PENABLE   = 1'b0;
        PWRITE    = wr;
        PADDR     = addr;
        PWDATA    = wdata;
        last_strb = strb;
`ifdef APB_REGFILE_PSTRB_EN
        PSTRB     = strb;
`endif
        sb_q.push_back('{exp_rdata, exp_err});
        @(negedge PCLK);
        PENABLE = 1'b1;
        n = 1;
        while (PREADY !== 1'b1 && n < 16) begin
            @(negedge PCLK);
            n++;
        end
        chk({name, "_ready"}, {31'b0, PREADY}, 32'd1);
        chk({name, "_acc_cycles"}, n, WS + 1);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_prdata"}, PRDATA, e.rdata);
            chk({name, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h04, 32'h0,          32'hA5A5_0000, 1'b0};
        vecs[1]  = '{1'b0, 8'h1C, 32'h0,          32'h1234_9876, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,          32'h0,         1'b0};
        vecs[3]  = '{1'b1, 8'h08, 32'hDEAD_BEEF,  32'h0,         1'b0};
        vecs[4]  = '{1'b0, 8'h08, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 8'h1C, 32'hFFFF_FFFF,  32'h0,         1'b1};
        vecs[6]  = '{1'b0, 8'h1C, 32'h0,          32'h1234_9876, 1'b0};
        vecs[7]  = '{1'b0, 8'h20, 32'h0,          32'h0,         1'b1};
        vecs[8]  = '{1'b1, 8'h24, 32'hCAFE_F00D,  32'h0,         1'b1};
        vecs[9]  = '{1'b1, 8'h0E, 32'h0BAD_F00D,  32'h0,         1'b0};
        vecs[10] = '{1'b0, 8'h0C, 32'h0,          32'h0BAD_F00D, 1'b0};
        vecs[11] = '{1'b1, 8'hFC, 32'h0000_0001,  32'h0,         1'b1};
        vecs[12] = '{1'b0, 8'h00, 32'h0,          32'h0,         1'b0};
        vecs[13] = '{1'b0, 8'h04, 32'h0,          32'hA5A5_0000, 1'b0};
        vecs[14] = '{1'b0, 8'h08, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[15] = '{1'b0, 8'h0C, 32'h0,          32'h0BAD_F00D, 1'b0};
        vecs[16] = '{1'b0, 8'h10, 32'h0,          32'h0,         1'b0};
        vecs[17] = '{1'b0, 8'h14, 32'h0,          32'h0,         1'b0};
        vecs[18] = '{1'b0, 8'h18, 32'h0,          32'h0,         1'b0};
        vecs[19] = '{1'b0, 8'h1C, 32'h0,          32'h1234_9876, 1'b0};

        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
`ifdef APB_REGFILE_PSTRB_EN
        PSTRB   = 4'hF;
`endif
        repeat (3) @(negedge PCLK);
        chk("rst_pready",  {31'b0, PREADY},  32'd0);
        chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
        chk("rst_prdata",  PRDATA,           32'd0);
        PRESET = 1'b0;

        // Table: mix back-to-back transfers with idle gaps.
        for (int i = 0; i < 20; i++) begin
            xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF,
                 vecs[i].rdata, vecs[i].err);
            if (i % 3 == 2) idle();
        end
        idle();

        // Reset asserted during ACCESS, on the would-be commit edge.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h5555_AAAA;
        @(negedge PCLK);
        PENABLE = 1'b1;
        chk("rstx_acc1_ready", {31'b0, PREADY}, 32'd0);
        @(negedge PCLK);
        chk("rstx_acc2_ready", {31'b0, PREADY}, 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rstx_pready",  {31'b0, PREADY},  32'd0);
        chk("rstx_pslverr", {31'b0, PSLVERR}, 32'd0);
        chk("rstx_prdata",  PRDATA,           32'd0);
        @(negedge PCLK);
        chk("rstx_idle_ready", {31'b0, PREADY}, 32'd0);
        idle();
        xfer("rstx_rd0c", 1'b0, 8'h0C, 32'h0, 4'hF, 32'h0,         1'b0);
        xfer("rstx_rd04", 1'b0, 8'h04, 32'h0, 4'hF, 32'hA5A5_0000, 1'b0);
        xfer("rstx_rd08", 1'b0, 8'h08, 32'h0, 4'hF, 32'h0,         1'b0);
        idle();

        // Abort: PSEL dropped after PREADY rose but before completion.
        xfer("abt_wr", 1'b1, 8'h0C, 32'h0000_0077, 4'hF, 32'h0, 1'b0);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h5555_AAAA;
        @(negedge PCLK);
        PENABLE = 1'b1;
        chk("abt_acc1_ready", {31'b0, PREADY}, 32'd0);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("abt_after_ready", {31'b0, PREADY}, 32'd0);
        xfer("abt_rd0c", 1'b0, 8'h0C, 32'h0, 4'hF, 32'h0000_0077, 1'b0);
        idle();

`ifdef APB_REGFILE_PSTRB_EN
        xfer("strb_full",  1'b1, 8'h10, 32'h1122_3344, 4'hF,    32'h0,         1'b0);
        xfer("strb_0101",  1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0);
        xfer("strb_none",  1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0,         1'b0);
        xfer("strb_rd",    1'b0, 8'h10, 32'h0,         4'b0000, 32'h11BB_33DD, 1'b0);
        idle();
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_ws.md
Name: apb_regfile_ws

Overview:
Parametrised APB3 slave register file. Successor to the fixed five-register APB slave, adding:
- configurable register count and data width
- per-register reset values and read-only mask
- programmable wait states on PREADY
- PSLVERR on illegal accesses

Sits behind the APB interconnect as a generic control/status bank, and is the default target for RAL model tests.

Parameters:
NUM_REGS, 8, number of registers (1..64)
DATA_WIDTH, 32, register and bus data width (multiple of 8, 8..64)
ADDR_WIDTH, 8, PADDR width; must satisfy 2^(ADDR_WIDTH-2) >= NUM_REGS
WAIT_STATES, 1, number of access-phase cycles with PREADY low before completion (0..15)
RO_MASK, {NUM_REGS{1'b0}}, bit i set = register i is read-only
RESET_VALS, {NUM_REGS*DATA_WIDTH{1'b0}}, packed reset values; register i = RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH]

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  synchronous active-high reset
PSEL  input  1  slave select
PENABLE  input  1  access phase
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_WIDTH  byte address; word index = PADDR[ADDR_WIDTH-1:2], PADDR[1:0] ignored
PWDATA  input  DATA_WIDTH  write data
PRDATA  output  DATA_WIDTH  read data, registered
PREADY  output  1  transfer complete, registered
PSLVERR  output  1  transfer error, valid only while PREADY=1

Behaviour:
- One clock (PCLK); reset is synchronous and active-high (PRESET).
- Reset (PRESET=1 at a PCLK edge, any state, including mid-transfer):
  - register i <- RESET_VALS slice i
  - PRDATA=0, PREADY=0, PSLVERR=0
  - FSM=IDLE, wait counter=0
  - in-flight transfer is dropped with no write.
- FSM states:
  - IDLE: PSEL=0. PSEL=1 & PENABLE=0 -> SETUP.
  - SETUP: latch index, PWRITE and PWDATA; clear counter. Next cycle -> ACCESS. If WAIT_STATES=0, PREADY registers high at this edge.
  - ACCESS: while PREADY=0, counter increments each cycle; PREADY registers high on the edge where counter reaches WAIT_STATES-1. The transfer therefore completes in access cycle WAIT_STATES+1.
  - Completing cycle (PSEL & PENABLE & PREADY): go to IDLE, or to SETUP if the next setup phase is already presented. PREADY and PSLVERR return to 0 the following cycle.
- Abort: PSEL=0 while in ACCESS before completion -> IDLE, counter cleared, PREADY=0, no register update.
- Error conditions, checked at SETUP:
  - index >= NUM_REGS -> PSLVERR=1 in the completing cycle; a write is discarded; a read returns PRDATA=0.
  - write to a register with RO_MASK[index]=1 -> PSLVERR=1 and the register is unchanged.
  - a read of an RO register is legal.
- Write commit: register updated on the PCLK edge ending the completing cycle, using PWDATA latched at SETUP.
- Read: PRDATA loaded on the edge that raises PREADY. Otherwise PRDATA=0.
- Back-to-back transfers: a read immediately after a write to the same register returns the new value.
- Out-of-range index arithmetic: no wrap; it is always an error.

Optional Feature:
Macro APB_REGFILE_PSTRB_EN.
- Defined: adds input port PSTRB, width DATA_WIDTH/8, latched at SETUP. Only bytes with PSTRB[b]=1 are written. PSTRB=0 on a write is a legal no-op (PSLVERR=0). PSTRB is ignored on reads.
- Undefined: no PSTRB port; every write updates the full word.

Test Plan:
Bench configuration: NUM_REGS=8, DATA_WIDTH=32, WAIT_STATES=1, RO_MASK=8'h80, RESET_VALS reg1=32'hA5A5_0000, reg7=32'h1234_9876, all others 0.
1. Reset then read 0x04 and 0x1C -> PRDATA 32'hA5A5_0000 and 32'h1234_9876; PREADY high in the 2nd access cycle; PSLVERR=0.
2. Write 0x08 <- 32'hDEAD_BEEF, then read 0x08 -> 32'hDEAD_BEEF; PREADY low for exactly 1 access cycle on each transfer.
3. Write 0x1C <- 32'hFFFF_FFFF -> PSLVERR=1 at completion; a subsequent read of 0x1C returns 32'h1234_9876.
4. Read 0x20 (index 8) -> PSLVERR=1, PRDATA=0. Write 0x24 -> PSLVERR=1, and all 8 registers are unchanged.
5. Start a write to 0x0C <- 32'h5555_AAAA and assert PRESET during ACCESS -> PREADY=0 and FSM IDLE next cycle; register 0x0C reads 0. Separately, dropping PSEL mid-ACCESS leaves 0x0C unchanged.
6. With APB_REGFILE_PSTRB_EN: write 0x10 <- 32'h1122_3344, then write 32'hAABB_CCDD with PSTRB=4'b0101 -> reading 0x10 returns 32'h11BB_33DD.
